peripheral_gpio_irq_apb4: RTL
=============================

Name: peripheral_gpio_irq_apb4

Overview:
- Next-generation APB4 GPIO peripheral with a parametrised bus width, pin count and synchroniser depth.
- Adds per-pin open-drain mode, level/edge interrupt triggers, W1C status and byte-strobed writes.
- Sits on the APB4 peripheral bus, driven by the APB4 BFM in block-level benches and by the SoC APB bridge in system builds.

Parameters:
- PDATA_SIZE, 32, APB data width; multiple of 8.
- PADDR_SIZE, 4, APB word-address width; register index = PADDR.
- GPIO_PINS, 16, number of pins; ≤ PDATA_SIZE; unused register bits read 0 and ignore writes.
- SYNC_DEPTH, 2, flops in the gpio_i synchroniser; ≥ 2.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PADDR  in  PADDR_SIZE  register index.
- PWRITE  in  1  1 = write.
- PSTRB  in  PDATA_SIZE/8  write byte enables.
- PWDATA  in  PDATA_SIZE  write data.
- PRDATA  out  PDATA_SIZE  read data, registered.
- PREADY  out  1  always 1 (zero wait states).
- PSLVERR  out  1  error on unmapped index.
- gpio_i  in  GPIO_PINS  asynchronous pin inputs.
- gpio_o  out  GPIO_PINS  pin output values.
- gpio_oe  out  GPIO_PINS  pin output enables.
- irq_o  out  1  interrupt, registered.

Behaviour:
Register map (index: name):
- 0: MODE. 1 = open-drain.
- 1: DIRECTION. 1 = output.
- 2: OUTPUT.
- 3: INPUT. Read-only; synchronised value.
- 4: TRIGGER_TYPE. 0 = level, 1 = edge.
- 5: TRIGGER_LVL0. Enables low-level / falling-edge trigger.
- 6: TRIGGER_LVL1. Enables high-level / rising-edge trigger.
- 7: TRIGGER_STATUS. Write-1-to-clear.
- 8: IRQ_ENA.
- Others: unmapped.

Reset:
- All registers, PRDATA, PSLVERR, irq_o, gpio_o and gpio_oe = 0.
- PREADY = 1.
- Synchroniser and edge-history flops = 0.

APB access:
- Write commits on PSEL & PENABLE & PWRITE. Only bytes with PSTRB[n]=1 are updated.
- Writes to INPUT are ignored, with no error.
- Read: PRDATA is loaded in the setup cycle (PSEL & ~PENABLE & ~PWRITE) and is stable through the access cycle. PRDATA holds its value otherwise.
- PSLVERR = 1 during the access cycle of any access to an unmapped index. Such a read returns 0; such a write has no effect.

Pins:
- Push-pull (MODE=0): gpio_o = OUTPUT; gpio_oe = DIRECTION.
- Open-drain (MODE=1): gpio_o = 0; gpio_oe = DIRECTION & ~OUTPUT.
- Outputs are combinational from registers, so a pin changes in the cycle after the write commits.

Input path:
- gpio_i passes through SYNC_DEPTH flops to give `in_s`; INPUT = `in_s`.
- `in_d` is `in_s` delayed by one cycle.

Trigger (per pin, evaluated every cycle):
- Level mode: hit = (LVL1 & in_s) | (LVL0 & ~in_s).
- Edge mode: hit = (LVL1 & in_s & ~in_d) | (LVL0 & ~in_s & in_d).
- TRIGGER_STATUS bit is set on the edge after hit.
- Set takes priority over a W1C clear in the same cycle.
- Level triggers re-set every cycle while the condition holds.

Interrupt:
- irq_o <= |(TRIGGER_STATUS & IRQ_ENA), one cycle after the status update.

Latency (gpio_i edge to irq_o):
- gpio_i edge → INPUT: SYNC_DEPTH cycles.
- → STATUS: +1 cycle.
- → irq_o: +1 cycle.

Reset mid-operation:
- PRESET asserted at any time clears everything asynchronously, including a pending access.
- The first access after PRESET deasserts completes normally.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined:
  - Adds register 9, DEBOUNCE: a 16-bit count N, reset value 0.
  - A 16-bit stability counter is kept per pin, after the synchroniser.
  - `in_s` adopts a new value only after the synchronised value has been stable for N+1 consecutive cycles.
  - N=0 gives one extra cycle of latency versus the undefined build.
  - INPUT and the triggers both use the debounced value.
- Undefined:
  - No counters are built.
  - Index 9 is unmapped (PSLVERR, reads 0).

Test Plan:
- Reset: after PRESET pulse, read all indices 0–8 → 0; PSLVERR=0 throughout; read index 12 → PRDATA=0, PSLVERR=1.
- Byte strobe: write OUTPUT=0xFFFF_FFFF with PSTRB=4'b0001, DIRECTION=0xFFFF → gpio_o=0x00FF, gpio_oe=0xFFFF. Then set MODE=0x0001 → gpio_oe=0xFFFE... wait, bit0 OUTPUT=1, so gpio_oe[0]=0 and gpio_o[0]=0.
- Rising edge: TRIGGER_TYPE=0x0004, LVL1=0x0004, IRQ_ENA=0x0004; drive gpio_i[2] 0→1 → irq_o=1 exactly SYNC_DEPTH+2 cycles later. Then write STATUS=0x0004 → irq_o falls 2 cycles later and stays 0.
- Level retrigger: level mode, LVL0=0x0001, gpio_i[0]=0 held; write STATUS=0x0001 → status bit reads 1 again on the next read; irq_o stays 1.
- Simultaneous set/clear: W1C to bit 3 in the same cycle as a new falling edge on pin 3 → status bit 3 remains 1.
- Debounce (macro defined): DEBOUNCE=4; glitch gpio_i[1] high for 3 cycles → INPUT[1] stays 0; hold high for 10 cycles → INPUT[1]=1.

Source files
------------

// File: rtl/peripheral_gpio_irq_apb4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : peripheral_gpio_irq_apb4                                   |
// | Description : APB4 GPIO peripheral with per-pin open-drain mode,         |
// |               level/edge interrupt triggers, write-1-to-clear status     |
// |               and byte-strobed register writes.                          |
// |               Optional input debounce enabled by GPIO_DEBOUNCE_EN.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module peripheral_gpio_irq_apb4 #(
    parameter int PDATA_SIZE = 32,
    parameter int PADDR_SIZE = 4,
    parameter int GPIO_PINS  = 16,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [GPIO_PINS-1:0]    gpio_i,
    output logic [GPIO_PINS-1:0]    gpio_o,
    output logic [GPIO_PINS-1:0]    gpio_oe,
    output logic                    irq_o
);

    // Register indices
    localparam logic [PADDR_SIZE-1:0] c_IDX_MODE     = PADDR_SIZE'(0);
    localparam logic [PADDR_SIZE-1:0] c_IDX_DIR      = PADDR_SIZE'(1);
    localparam logic [PADDR_SIZE-1:0] c_IDX_OUTPUT   = PADDR_SIZE'(2);
    localparam logic [PADDR_SIZE-1:0] c_IDX_INPUT    = PADDR_SIZE'(3);
    localparam logic [PADDR_SIZE-1:0] c_IDX_TTYPE    = PADDR_SIZE'(4);
    localparam logic [PADDR_SIZE-1:0] c_IDX_LVL0     = PADDR_SIZE'(5);
    localparam logic [PADDR_SIZE-1:0] c_IDX_LVL1     = PADDR_SIZE'(6);
    localparam logic [PADDR_SIZE-1:0] c_IDX_STATUS   = PADDR_SIZE'(7);
    localparam logic [PADDR_SIZE-1:0] c_IDX_IRQ_ENA  = PADDR_SIZE'(8);
`ifdef GPIO_DEBOUNCE_EN
    localparam logic [PADDR_SIZE-1:0] c_IDX_DEBOUNCE = PADDR_SIZE'(9);
    localparam logic [PADDR_SIZE-1:0] c_IDX_LAST     = PADDR_SIZE'(9);
`else
    localparam logic [PADDR_SIZE-1:0] c_IDX_LAST     = PADDR_SIZE'(8);
`endif

    // Programmer-visible registers
    logic [GPIO_PINS-1:0]  r_mode;
    logic [GPIO_PINS-1:0]  r_direction;
    logic [GPIO_PINS-1:0]  r_output;
    logic [GPIO_PINS-1:0]  r_trig_type;
    logic [GPIO_PINS-1:0]  r_lvl0;
    logic [GPIO_PINS-1:0]  r_lvl1;
    logic [GPIO_PINS-1:0]  r_status;
    logic [GPIO_PINS-1:0]  r_irq_ena;

    // Bus-side registered outputs
    logic [PDATA_SIZE-1:0] r_prdata;
    logic                  r_slverr;
    logic                  r_irq;

    // Input path
    logic [GPIO_PINS-1:0]  r_sync [SYNC_DEPTH];
    logic [GPIO_PINS-1:0]  w_sync_out;
    logic [GPIO_PINS-1:0]  w_in_s;
    logic [GPIO_PINS-1:0]  r_in_d;

    // Bus decode and write helpers
    logic                  w_wr_en;
    logic                  w_rd_setup;
    logic                  w_mapped;
    logic [GPIO_PINS-1:0]  w_wmask;
    logic [GPIO_PINS-1:0]  w_wpins;
    logic [GPIO_PINS-1:0]  w_clr;
    logic [GPIO_PINS-1:0]  w_hit;
    logic [PDATA_SIZE-1:0] w_rdata;
    logic                  w_unused_ok;

    assign w_wr_en    = PSEL & PENABLE & PWRITE;
    assign w_rd_setup = PSEL & ~PENABLE & ~PWRITE;
    assign w_mapped   = (PADDR <= c_IDX_LAST);
    assign w_wpins    = PWDATA[GPIO_PINS-1:0];

    // Data and strobe bits above the pin count carry no state
    assign w_unused_ok = ^{PWDATA, PSTRB};

    // Expand the byte strobes to one enable per pin bit
    for (genvar i = 0; i < GPIO_PINS; i++) begin : g_wmask
        assign w_wmask[i] = PSTRB[i/8];
    end

    function automatic logic [GPIO_PINS-1:0] f_merge(
        input logic [GPIO_PINS-1:0] old_val,
        input logic [GPIO_PINS-1:0] new_val,
        input logic [GPIO_PINS-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0]          r_debounce;
    logic [15:0]          r_cnt [GPIO_PINS];
    logic [GPIO_PINS-1:0] r_deb_s;
    logic [15:0]          w_dmask;

    assign w_dmask = {{8{PSTRB[1]}}, {8{PSTRB[0]}}};
`endif

    // Byte-strobed writes to the read/write configuration registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_mode      <= '0;
            r_direction <= '0;
            r_output    <= '0;
            r_trig_type <= '0;
            r_lvl0      <= '0;
            r_lvl1      <= '0;
            r_irq_ena   <= '0;
`ifdef GPIO_DEBOUNCE_EN
            r_debounce  <= '0;
`endif
        end else if (w_wr_en) begin
            case (PADDR)
                c_IDX_MODE:     r_mode      <= f_merge(r_mode, w_wpins, w_wmask);
                c_IDX_DIR:      r_direction <= f_merge(r_direction, w_wpins, w_wmask);
                c_IDX_OUTPUT:   r_output    <= f_merge(r_output, w_wpins, w_wmask);
                c_IDX_TTYPE:    r_trig_type <= f_merge(r_trig_type, w_wpins, w_wmask);
                c_IDX_LVL0:     r_lvl0      <= f_merge(r_lvl0, w_wpins, w_wmask);
                c_IDX_LVL1:     r_lvl1      <= f_merge(r_lvl1, w_wpins, w_wmask);
                c_IDX_IRQ_ENA:  r_irq_ena   <= f_merge(r_irq_ena, w_wpins, w_wmask);
`ifdef GPIO_DEBOUNCE_EN
                c_IDX_DEBOUNCE: r_debounce  <= (r_debounce & ~w_dmask) | (PWDATA[15:0] & w_dmask);
`endif
                default: ;
            endcase
        end
    end

    // Multi-flop synchroniser for the asynchronous pin inputs
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int k = 0; k < SYNC_DEPTH; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= gpio_i;
            for (int k = 1; k < SYNC_DEPTH; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_DEPTH-1];

`ifdef GPIO_DEBOUNCE_EN
    // Per-pin stability counter: adopt a new level once it has held N+1 cycles
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_deb_s <= '0;
            for (int p = 0; p < GPIO_PINS; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < GPIO_PINS; p++) begin
                if (w_sync_out[p] == r_deb_s[p]) begin
                    r_cnt[p] <= '0;
                end else if (r_cnt[p] == r_debounce) begin
                    r_deb_s[p] <= w_sync_out[p];
                    r_cnt[p]   <= '0;
                end else begin
                    r_cnt[p] <= r_cnt[p] + 16'd1;
                end
            end
        end
    end

    assign w_in_s = r_deb_s;
`else
    assign w_in_s = w_sync_out;
`endif

    // One-cycle history of the conditioned input for edge detection
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_in_d <= '0;
        end else begin
            r_in_d <= w_in_s;
        end
    end

    // Level mode compares the current value; edge mode compares against history
    assign w_hit = ( r_trig_type & ((r_lvl1 & w_in_s & ~r_in_d) | (r_lvl0 & ~w_in_s & r_in_d)))
                 | (~r_trig_type & ((r_lvl1 & w_in_s)           | (r_lvl0 & ~w_in_s)));

    assign w_clr = (w_wr_en && (PADDR == c_IDX_STATUS)) ? (w_wpins & w_wmask) : '0;

    // Sticky trigger status: new hits win over a simultaneous W1C clear
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_clr) | w_hit;
        end
    end

    // Interrupt follows the registered status by one cycle
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_status & r_irq_ena);
        end
    end

    // Read-data selection; unmapped indices return zero
    always_comb begin
        w_rdata = '0;
        case (PADDR)
            c_IDX_MODE:     w_rdata = PDATA_SIZE'(r_mode);
            c_IDX_DIR:      w_rdata = PDATA_SIZE'(r_direction);
            c_IDX_OUTPUT:   w_rdata = PDATA_SIZE'(r_output);
            c_IDX_INPUT:    w_rdata = PDATA_SIZE'(w_in_s);
            c_IDX_TTYPE:    w_rdata = PDATA_SIZE'(r_trig_type);
            c_IDX_LVL0:     w_rdata = PDATA_SIZE'(r_lvl0);
            c_IDX_LVL1:     w_rdata = PDATA_SIZE'(r_lvl1);
            c_IDX_STATUS:   w_rdata = PDATA_SIZE'(r_status);
            c_IDX_IRQ_ENA:  w_rdata = PDATA_SIZE'(r_irq_ena);
`ifdef GPIO_DEBOUNCE_EN
            c_IDX_DEBOUNCE: w_rdata = PDATA_SIZE'(r_debounce);
`endif
            default:        w_rdata = '0;
        endcase
    end

    // Read data captured in the setup cycle and held until the next read
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_prdata <= '0;
        end else if (w_rd_setup) begin
            r_prdata <= w_rdata;
        end
    end

    // Error flag raised for exactly the access cycle of an unmapped access
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_slverr <= 1'b0;
        end else begin
            r_slverr <= PSEL & ~PENABLE & ~w_mapped;
        end
    end

    assign PRDATA  = r_prdata;
    assign PSLVERR = r_slverr;
    assign PREADY  = 1'b1;
    assign irq_o   = r_irq;

    // Open-drain pins never drive high: they release (oe=0) to signal a one
    assign gpio_o  = r_output & ~r_mode;
    assign gpio_oe = r_direction & ~(r_mode & r_output);

endmodule
`default_nettype wire
